// File: rtl/axi4_fb_line_fetcher.sv
// AXI4 read master that fetches one framebuffer scanline into an external line buffer.
// Optional `FBREADER_RESP_CHECK_EN: rresp errors and rlast mismatches also raise err.
module axi4_fb_line_fetcher #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ID_WIDTH   = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR0 = 32'h8100_0000,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR1 = 32'h8109_6000,
  parameter int                    H_RES      = 640,
  parameter int                    V_RES      = 480,
  parameter int                    BPP        = 16,
  parameter int                    BURST_LEN  = 64
) (
  input  logic                                       m00_axi_aclk,
  input  logic                                       m00_axi_areset,
  input  logic                                       line_req,
  input  logic [$clog2(V_RES)-1:0]                   line_idx,
  input  logic                                       fb_sel,
  output logic                                       busy,
  output logic                                       line_done,
  output logic                                       err,
  output logic                                       wr_en,
  output logic [$clog2(H_RES*BPP/DATA_WIDTH)-1:0]    wr_addr,
  output logic [DATA_WIDTH-1:0]                      wr_data,
  output logic [ID_WIDTH-1:0]                        m00_axi_arid,
  output logic [ADDR_WIDTH-1:0]                      m00_axi_araddr,
  output logic [7:0]                                 m00_axi_arlen,
  output logic [2:0]                                 m00_axi_arsize,
  output logic [1:0]                                 m00_axi_arburst,
  output logic                                       m00_axi_arlock,
  output logic [3:0]                                 m00_axi_arcache,
  output logic [2:0]                                 m00_axi_arprot,
  output logic [3:0]                                 m00_axi_arqos,
  output logic                                       m00_axi_arvalid,
  input  logic                                       m00_axi_arready,
  input  logic [ID_WIDTH-1:0]                        m00_axi_rid,
  input  logic [DATA_WIDTH-1:0]                      m00_axi_rdata,
  input  logic [1:0]                                 m00_axi_rresp,
  input  logic                                       m00_axi_rlast,
  input  logic                                       m00_axi_rvalid,
  output logic                                       m00_axi_rready
);

  localparam int LINE_BEATS     = H_RES * BPP / DATA_WIDTH;
  localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;
  localparam int LINE_BYTES     = LINE_BEATS * BYTES_PER_BEAT;
  localparam int WA_W           = $clog2(LINE_BEATS);
  localparam int CNT_W          = $clog2(LINE_BEATS + 1);
  localparam int FIRST_BEATS    = (LINE_BEATS < BURST_LEN) ? LINE_BEATS : BURST_LEN;
  localparam logic [2:0] AR_SIZE = 3'($clog2(BYTES_PER_BEAT));

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [7:0]              arlen_reg;
  logic [7:0]              burst_cnt_reg;
  logic [CNT_W-1:0]        beat_cnt_reg;
  logic                    err_reg;
  logic                    wr_en_reg;
  logic [WA_W-1:0]         wr_addr_reg;
  logic [DATA_WIDTH-1:0]   wr_data_reg;

  logic                    idx_ok;
  logic                    beat_fire;
  logic                    burst_last;
  logic                    line_last;
  logic [CNT_W-1:0]        beats_left;
  logic [7:0]              next_arlen;
  logic [ADDR_WIDTH-1:0]   start_addr;
  logic [ADDR_WIDTH-1:0]   burst_bytes;
  logic                    unused_inputs;

  assign idx_ok      = 32'(line_idx) < 32'(V_RES);
  assign beat_fire   = (state_reg == S_DATA) && m00_axi_rvalid;
  assign burst_last  = burst_cnt_reg == arlen_reg;
  assign line_last   = beat_cnt_reg == CNT_W'(LINE_BEATS - 1);
  // beats still to fetch once the current beat has been accepted
  assign beats_left  = CNT_W'(LINE_BEATS - 1) - beat_cnt_reg;
  assign next_arlen  = (32'(beats_left) >= 32'(BURST_LEN)) ? 8'(BURST_LEN - 1)
                                                            : 8'(beats_left - CNT_W'(1));
  assign start_addr  = (fb_sel ? BASE_ADDR1 : BASE_ADDR0)
                     + ADDR_WIDTH'(line_idx) * ADDR_WIDTH'(LINE_BYTES);
  assign burst_bytes = ADDR_WIDTH'((32'(arlen_reg) + 32'd1) * 32'(BYTES_PER_BEAT));
  assign unused_inputs = ^{m00_axi_rid, m00_axi_rresp, m00_axi_rlast};

  always_ff @(posedge m00_axi_aclk) begin
    if (m00_axi_areset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (line_req && idx_ok) state_next = S_ADDR;
      S_ADDR:  if (m00_axi_arready) state_next = S_DATA;
      S_DATA:  if (beat_fire && burst_last) state_next = line_last ? S_DONE : S_ADDR;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy            = state_reg != S_IDLE;
    line_done       = state_reg == S_DONE;
    m00_axi_arvalid = state_reg == S_ADDR;
    m00_axi_rready  = state_reg == S_DATA;
    m00_axi_arid    = '0;
    m00_axi_araddr  = addr_reg;
    m00_axi_arlen   = arlen_reg;
    // fixed AR fields are held at zero whenever no address is offered
    m00_axi_arsize  = m00_axi_arvalid ? AR_SIZE : 3'b000;
    m00_axi_arburst = m00_axi_arvalid ? 2'b01 : 2'b00;
    m00_axi_arcache = m00_axi_arvalid ? 4'b0011 : 4'b0000;
    m00_axi_arlock  = 1'b0;
    m00_axi_arprot  = 3'b000;
    m00_axi_arqos   = 4'b0000;
    err             = err_reg;
    wr_en           = wr_en_reg;
    wr_addr         = wr_addr_reg;
    wr_data         = wr_data_reg;
  end

  always_ff @(posedge m00_axi_aclk) begin
    if (m00_axi_areset) begin
      addr_reg      <= '0;
      arlen_reg     <= '0;
      burst_cnt_reg <= '0;
      beat_cnt_reg  <= '0;
      err_reg       <= 1'b0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
    end else begin
      wr_en_reg <= 1'b0;
      if (state_reg == S_IDLE && line_req) begin
        if (idx_ok) begin
          addr_reg      <= start_addr;
          arlen_reg     <= 8'(FIRST_BEATS - 1);
          burst_cnt_reg <= '0;
          beat_cnt_reg  <= '0;
        end else begin
          err_reg <= 1'b1;
        end
      end
      if (beat_fire) begin
        wr_en_reg    <= 1'b1;
        wr_addr_reg  <= WA_W'(beat_cnt_reg);
        wr_data_reg  <= m00_axi_rdata;
        beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
        if (burst_last) begin
          burst_cnt_reg <= '0;
          addr_reg      <= addr_reg + burst_bytes;
          arlen_reg     <= next_arlen;
        end else begin
          burst_cnt_reg <= burst_cnt_reg + 8'd1;
        end
`ifdef FBREADER_RESP_CHECK_EN
        // the beat counter still decides burst end; rlast is only cross-checked
        if ((m00_axi_rresp != 2'b00) || (m00_axi_rlast != burst_last)) begin
          err_reg <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_axi4_fb_line_fetcher.sv
// Scoreboard bench for axi4_fb_line_fetcher: directed line fetches against a small AXI slave model.
module tb_axi4_fb_line_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_req;
  logic [8:0]  line_idx;
  logic        fb_sel;
  logic        busy, line_done, err, wr_en;
  logic [7:0]  wr_addr;
  logic [63:0] wr_data;
  logic [0:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [3:0]  arqos;
  logic        arvalid, arready;
  logic [0:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  axi4_fb_line_fetcher dut (
    .m00_axi_aclk    (clk),
    .m00_axi_areset  (rst),
    .line_req        (line_req),
    .line_idx        (line_idx),
    .fb_sel          (fb_sel),
    .busy            (busy),
    .line_done       (line_done),
    .err             (err),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .m00_axi_arid    (arid),
    .m00_axi_araddr  (araddr),
    .m00_axi_arlen   (arlen),
    .m00_axi_arsize  (arsize),
    .m00_axi_arburst (arburst),
    .m00_axi_arlock  (arlock),
    .m00_axi_arcache (arcache),
    .m00_axi_arprot  (arprot),
    .m00_axi_arqos   (arqos),
    .m00_axi_arvalid (arvalid),
    .m00_axi_arready (arready),
    .m00_axi_rid     (rid),
    .m00_axi_rdata   (rdata),
    .m00_axi_rresp   (rresp),
    .m00_axi_rlast   (rlast),
    .m00_axi_rvalid  (rvalid),
    .m00_axi_rready  (rready)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;
  int wr_seen = 0;
  int arv_seen = 0;

  // slave behaviour knobs, set by the stimulus
  int          ar_delay = 0;
  logic        r_toggle = 1'b0;
  int          err_beat = -1;
  logic [31:0] line_base = '0;

  logic [31:0] exp_ar_addr[$];
  logic [7:0]  exp_ar_len[$];
  logic [7:0]  exp_wr_addr[$];
  logic [63:0] exp_wr_data[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents an AR handshake or a write
  initial begin
    logic        ar_hold;
    logic [31:0] held_addr, ea;
    logic [7:0]  held_len, el;
    ar_hold = 1'b0;
    held_addr = '0;
    held_len = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ar_hold = 1'b0;
        continue;
      end
      if (arvalid) begin
        arv_seen++;
        if (ar_hold) begin
          check("ar_addr_stable", araddr, held_addr);
          check("ar_len_stable", arlen, held_len);
        end
        if (arready) begin
          ar_hold = 1'b0;
          if (exp_ar_addr.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ar: got addr 0x%0h, want no request", araddr);
          end else begin
            ea = exp_ar_addr.pop_front();
            el = exp_ar_len.pop_front();
            check("araddr", araddr, ea);
            check("arlen", arlen, el);
            check("ar_fixed", {arid, arsize, arburst, arlock, arcache, arprot, arqos},
                  {1'b0, 3'd3, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000});
          end
        end else begin
          ar_hold   = 1'b1;
          held_addr = araddr;
          held_len  = arlen;
        end
      end
      if (wr_en) begin
        wr_seen++;
        if (exp_wr_addr.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_wr: got wr_addr %0d, want no write", wr_addr);
        end else begin
          check("wr_addr", wr_addr, exp_wr_addr.pop_front());
          check("wr_data", wr_data, exp_wr_data.pop_front());
        end
      end
      if (line_done) done_seen++;
    end
  end

  // AXI slave model: data of each beat is its index within the line
  initial begin
    logic        ar_hs, r_hs, rst_s, r_active, phase;
    logic [31:0] s_addr, b_addr, beat;
    logic [7:0]  s_len;
    int          b_left, ar_wait;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = '0;
    r_active = 1'b0; phase = 1'b0; b_addr = '0; b_left = 0; ar_wait = 0;
    forever begin
      @(negedge clk);
      ar_hs  = arvalid && arready;
      r_hs   = rvalid && rready;
      s_addr = araddr;
      s_len  = arlen;
      rst_s  = rst;
      @(posedge clk);
      #1;
      if (rst_s || rst) begin
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        r_active = 1'b0; ar_wait = 0;
        continue;
      end
      if (ar_hs) begin
        arready  = 1'b0;
        ar_wait  = 0;
        b_addr   = s_addr;
        b_left   = int'(s_len) + 1;
        r_active = 1'b1;
      end else if (arvalid && !arready) begin
        if (ar_wait >= ar_delay) arready = 1'b1;
        else ar_wait++;
      end
      if (r_hs) begin
        b_addr = b_addr + 32'd8;
        b_left--;
        if (b_left == 0) r_active = 1'b0;
      end
      if (r_active) begin
        phase  = ~phase;
        rvalid = r_toggle ? phase : 1'b1;
        beat   = (b_addr - line_base) >> 3;
        rdata  = 64'(beat);
        rlast  = (b_left == 1);
        rresp  = (int'(beat) == err_beat) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic request(input int idx, input logic sel);
    line_idx = 9'(idx);
    fb_sel   = sel;
    line_req = 1'b1;
    tick(1);
    line_req = 1'b0;
  endtask

  task automatic expect_line(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
    line_base = a0;
    exp_ar_addr.push_back(a0); exp_ar_len.push_back(8'd63);
    exp_ar_addr.push_back(a1); exp_ar_len.push_back(8'd63);
    exp_ar_addr.push_back(a2); exp_ar_len.push_back(8'd31);
    for (int i = 0; i < 160; i++) begin
      exp_wr_addr.push_back(8'(i));
      exp_wr_data.push_back(64'(i));
    end
  endtask

  task automatic clear_sb();
    exp_ar_addr.delete(); exp_ar_len.delete();
    exp_wr_addr.delete(); exp_wr_data.delete();
  endtask

  task automatic wait_done(input string name, input int start);
    int c;
    c = 0;
    while (done_seen == start && c < 3000) begin
      tick(1);
      c++;
    end
    check({name, "_done_in_time"}, 64'(c < 3000), 64'd1);
  endtask

  task automatic fetch(input string name, input int idx, input logic sel,
                       input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
    int d0;
    $display("[TB] %s: line_idx=%0d fb_sel=%0d first araddr 0x%0h", name, idx, sel, a0);
    expect_line(a0, a1, a2);
    d0 = done_seen;
    request(idx, sel);
    wait_done(name, d0);
    tick(5);
    check({name, "_done_count"}, 64'(done_seen - d0), 64'd1);
    check({name, "_ar_left"}, 64'(exp_ar_addr.size()), 64'd0);
    check({name, "_wr_left"}, 64'(exp_wr_addr.size()), 64'd0);
    check({name, "_busy_after"}, 64'(busy), 64'd0);
    clear_sb();
  endtask

  initial begin
    int d0, a0, w0, c;
    rst = 1'b1; line_req = 1'b0; line_idx = '0; fb_sel = 1'b0;
    tick(3);
    check("rst_ctrl", {busy, line_done, err, wr_en, arvalid, rready}, 64'd0);
    check("rst_araddr", araddr, 64'd0);
    check("rst_arlen", arlen, 64'd0);
    rst = 1'b0;
    tick(2);

    fetch("line0_fb0", 0, 1'b0, 32'h8100_0000, 32'h8100_0200, 32'h8100_0400);
    check("line0_err", err, 64'd0);
    fetch("line479_fb1", 479, 1'b1, 32'h8112_BB00, 32'h8112_BD00, 32'h8112_BF00);

    ar_delay = 5; r_toggle = 1'b1;
    fetch("stall_line1", 1, 1'b0, 32'h8100_0500, 32'h8100_0700, 32'h8100_0900);
    ar_delay = 0; r_toggle = 1'b0;
    check("stall_err", err, 64'd0);

    $display("[TB] invalid: line_idx=480");
    a0 = arv_seen; d0 = done_seen;
    request(480, 1'b0);
    tick(20);
    check("invalid_err", err, 64'd1);
    check("invalid_no_ar", 64'(arv_seen - a0), 64'd0);
    check("invalid_no_done", 64'(done_seen - d0), 64'd0);
    check("invalid_busy", busy, 64'd0);

    $display("[TB] busy_req: line_idx=2 then ignored line_idx=3");
    expect_line(32'h8100_0A00, 32'h8100_0C00, 32'h8100_0E00);
    d0 = done_seen;
    request(2, 1'b0);
    tick(10);
    request(3, 1'b1);
    wait_done("busy_req", d0);
    tick(300);
    check("busy_req_done_count", 64'(done_seen - d0), 64'd1);
    check("busy_req_wr_left", 64'(exp_wr_addr.size()), 64'd0);
    clear_sb();

    $display("[TB] reset mid burst 2: line_idx=0");
    expect_line(32'h8100_0000, 32'h8100_0200, 32'h8100_0400);
    w0 = wr_seen; c = 0;
    request(0, 1'b0);
    while (wr_seen - w0 < 80 && c < 1000) begin
      tick(1);
      c++;
    end
    check("mid_burst2_reached", 64'(c < 1000), 64'd1);
    rst = 1'b1;
    tick(1);
    check("midrst_outputs", {arvalid, rready, wr_en, busy, line_done, err}, 64'd0);
    clear_sb();
    rst = 1'b0;
    tick(2);
    fetch("after_reset", 5, 1'b1, 32'h8109_7900, 32'h8109_7B00, 32'h8109_7D00);

    err_beat = 10;
    fetch("rresp_beat10", 0, 1'b0, 32'h8100_0000, 32'h8100_0200, 32'h8100_0400);
    err_beat = -1;
`ifdef FBREADER_RESP_CHECK_EN
    check("rresp_err", err, 64'd1);
`else
    check("rresp_err_ignored", err, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
